// File: rtl/eth_xcvr_link_sequencer.sv
// eth_xcvr_link_sequencer: shared-QPLL and per-channel transceiver bring-up, retry and link supervision.
// Channel FSMs only leave CH_OFF while the PLL is locked; PLL loss drops every channel back to CH_OFF.
module eth_xcvr_link_sequencer #(
    parameter int CH_COUNT         = 2,
    parameter int PLL_RST_CYCLES   = 16,
    parameter int PLL_LOCK_TIMEOUT = 65536,
    parameter int CH_RST_CYCLES    = 16,
    parameter int STABLE_CYCLES    = 1024,
    parameter int LOCK_TIMEOUT     = 1000000,
    parameter int LED_BLINK_BIT    = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_lock,
    output logic                  pll_reset,
    input  logic [CH_COUNT-1:0]   ch_enable,
    input  logic [CH_COUNT-1:0]   ch_block_lock,
    output logic [CH_COUNT-1:0]   ch_reset,
    output logic [CH_COUNT-1:0]   ch_up,
    output logic [8*CH_COUNT-1:0] ch_retry_count,
    output logic [CH_COUNT-1:0]   ch_led,
    output logic                  all_up
);
    localparam int PMAX = (PLL_LOCK_TIMEOUT > PLL_RST_CYCLES) ? PLL_LOCK_TIMEOUT : PLL_RST_CYCLES;
    localparam int CMAX = (LOCK_TIMEOUT > CH_RST_CYCLES) ? LOCK_TIMEOUT : CH_RST_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [PW-1:0] P_RST_END = PW'(PLL_RST_CYCLES - 1);
    localparam logic [PW-1:0] P_TO_END  = PW'(PLL_LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] C_RST_END = CW'(CH_RST_CYCLES - 1);
    localparam logic [CW-1:0] C_TO_END  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] S_END     = SW'(STABLE_CYCLES);

    typedef enum logic [1:0] {PLL_RST, PLL_WAIT, PLL_OK} pll_state_t;
    typedef enum logic [1:0] {CH_OFF, CH_RST, CH_WAIT, CH_UP} ch_state_t;

    logic [1:0]             pll_sync;
    logic [CH_COUNT-1:0]    lock_s1, lock_s;
    logic [LED_BLINK_BIT:0] blink;
    logic                   pll_lock_s, pll_ok, pll_loss;
    pll_state_t             pll_st, pll_nx;
    logic [PW-1:0]          pll_tmr, pll_tmr_nx;
    logic [CH_COUNT-1:0]    up_nx;

    assign pll_lock_s = pll_sync[1];
    assign pll_ok     = (pll_st == PLL_OK);
    assign pll_loss   = pll_ok && !pll_lock_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_sync <= '0;
            lock_s1  <= '0;
            lock_s   <= '0;
            blink    <= '0;
        end else begin
            pll_sync <= {pll_sync[0], pll_lock};
            lock_s1  <= ch_block_lock;
            lock_s   <= lock_s1;
            blink    <= blink + 1'b1;
        end
    end

    always_comb begin
        pll_nx     = pll_st;
        pll_tmr_nx = pll_tmr + 1'b1;
        case (pll_st)
            PLL_RST: begin
                if (pll_tmr == P_RST_END) begin
                    pll_nx     = PLL_WAIT;
                    pll_tmr_nx = '0;
                end
            end
            PLL_WAIT: begin
                if (pll_lock_s) begin
                    pll_nx     = PLL_OK;
                    pll_tmr_nx = '0;
                end else if (pll_tmr == P_TO_END) begin
                    pll_nx     = PLL_RST;
                    pll_tmr_nx = '0;
                end
            end
            default: begin
                pll_tmr_nx = '0;
                if (!pll_lock_s) pll_nx = PLL_RST;
            end
        endcase
    end

    // all_up looks at next-state values so it rises together with the last ch_up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_st    <= PLL_RST;
            pll_tmr   <= '0;
            pll_reset <= 1'b1;
            all_up    <= 1'b0;
        end else begin
            pll_st    <= pll_nx;
            pll_tmr   <= pll_tmr_nx;
            pll_reset <= (pll_nx == PLL_RST);
            all_up    <= (pll_nx == PLL_OK) && (|ch_enable) && (&(up_nx | ~ch_enable));
        end
    end

    for (genvar i = 0; i < CH_COUNT; i++) begin : g_ch
        ch_state_t     st, nx;
        logic [CW-1:0] tmr, tmr_nx;
        logic [SW-1:0] stb, stb_nx;
        logic [7:0]    rty, rty_nx, rty_inc;
        logic          lk, reset_q, up_q, led_q;

        assign lk      = lock_s[i];
        assign rty_inc = (rty == 8'hFF) ? rty : rty + 8'd1;
        assign up_nx[i] = (nx == CH_UP);

        always_comb begin
            nx     = st;
            tmr_nx = tmr + 1'b1;
            stb_nx = '0;
            rty_nx = rty;
            if (pll_loss || !ch_enable[i]) begin
                nx     = CH_OFF;
                tmr_nx = '0;
            end else begin
                case (st)
                    CH_OFF: begin
                        tmr_nx = '0;
                        if (pll_ok) nx = CH_RST;
                    end
                    CH_RST: begin
                        if (tmr == C_RST_END) begin
                            nx     = CH_WAIT;
                            tmr_nx = '0;
                        end
                    end
                    CH_WAIT: begin
                        stb_nx = !lk ? '0 : (stb == S_END) ? stb : stb + 1'b1;
                        if (lk && stb == S_END) begin
                            nx     = CH_UP;
                            tmr_nx = '0;
                        end else if (tmr == C_TO_END) begin
                            nx     = CH_RST;
                            tmr_nx = '0;
                            rty_nx = rty_inc;
                        end
                    end
                    default: begin
                        tmr_nx = '0;
                        if (!lk) begin
                            nx     = CH_WAIT;
                            rty_nx = rty_inc;
                        end
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st      <= CH_OFF;
                tmr     <= '0;
                stb     <= '0;
                rty     <= '0;
                reset_q <= 1'b1;
                up_q    <= 1'b0;
                led_q   <= 1'b0;
            end else begin
                st      <= nx;
                tmr     <= tmr_nx;
                stb     <= stb_nx;
                rty     <= rty_nx;
                reset_q <= (nx == CH_OFF) || (nx == CH_RST);
                up_q    <= (nx == CH_UP);
                led_q   <= (nx == CH_UP) || ((nx == CH_WAIT) && blink[LED_BLINK_BIT]);
            end
        end

        assign ch_reset[i]              = reset_q;
        assign ch_up[i]                 = up_q;
        assign ch_led[i]                = led_q;
        assign ch_retry_count[8*i +: 8] = rty;
    end
endmodule
